// File: rtl/alu_arb.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Accepts one operation, drives the ALU for one cycle, then holds the result until the consumer takes it.
module alu_arb #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        REQ0_VLD,
    output logic        REQ0_RDY,
    input  logic        REQ0_RCC,
    input  logic [2:0]  REQ0_FCT3,
    input  logic [6:0]  REQ0_FCT7,
    input  logic [31:0] REQ0_OP1,
    input  logic [31:0] REQ0_OP2,
    input  logic        REQ1_VLD,
    output logic        REQ1_RDY,
    input  logic        REQ1_RCC,
    input  logic [2:0]  REQ1_FCT3,
    input  logic [6:0]  REQ1_FCT7,
    input  logic [31:0] REQ1_OP1,
    input  logic [31:0] REQ1_OP2,
    output logic        ALU_RCC,
    output logic [2:0]  ALU_FCT3,
    output logic [6:0]  ALU_FCT7,
    output logic [31:0] ALU_U1REG,
    output logic [31:0] ALU_S1REG,
    output logic [31:0] ALU_U2REGX,
    output logic [31:0] ALU_S2REGX,
    input  logic [31:0] ALU_RMDATA,
    output logic        RSP_VLD,
    input  logic        RSP_RDY,
    output logic        RSP_ID,
    output logic [31:0] RSP_DATA,
    output logic        BUSY
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        owner_q, owner_d;
    logic        rcc_q, rcc_d;
    logic [2:0]  fct3_q, fct3_d;
    logic [6:0]  fct7_q, fct7_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic        rsp_vld_q, rsp_vld_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_data_q, rsp_data_d;

    logic gnt_id;
    logic can_accept;
    logic accept;

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q    <= IDLE;
            last_q     <= ~RR_INIT;
            owner_q    <= 1'b0;
            rcc_q      <= 1'b0;
            fct3_q     <= 3'd0;
            fct7_q     <= 7'd0;
            op1_q      <= 32'd0;
            op2_q      <= 32'd0;
            rsp_vld_q  <= 1'b0;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            rcc_q      <= rcc_d;
            fct3_q     <= fct3_d;
            fct7_q     <= fct7_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    always_comb begin
        // Tie goes to whoever was not granted last; otherwise the sole valid requester.
        gnt_id     = (REQ0_VLD && REQ1_VLD) ? ~last_q : REQ1_VLD;
        can_accept = (state_q == IDLE) || ((state_q == RESP) && RSP_RDY);
        accept     = can_accept && (REQ0_VLD || REQ1_VLD);
        REQ0_RDY   = accept && !gnt_id;
        REQ1_RDY   = accept && gnt_id;

        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        rcc_d      = rcc_q;
        fct3_d     = fct3_q;
        fct7_d     = fct7_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        rsp_vld_d  = rsp_vld_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;

        case (state_q)
            EXEC: begin
                rsp_data_d = ALU_RMDATA;
                rsp_id_d   = owner_q;
                rsp_vld_d  = 1'b1;
                state_d    = RESP;
            end
            RESP: begin
                if (RSP_RDY) begin
                    rsp_vld_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            last_d  = gnt_id;
            owner_d = gnt_id;
            rcc_d   = gnt_id ? REQ1_RCC  : REQ0_RCC;
            fct3_d  = gnt_id ? REQ1_FCT3 : REQ0_FCT3;
            fct7_d  = gnt_id ? REQ1_FCT7 : REQ0_FCT7;
            op1_d   = gnt_id ? REQ1_OP1  : REQ0_OP1;
            op2_d   = gnt_id ? REQ1_OP2  : REQ0_OP2;
            state_d = EXEC;
        end
    end

    assign ALU_RCC    = rcc_q;
    assign ALU_FCT3   = fct3_q;
    assign ALU_FCT7   = fct7_q;
    assign ALU_U1REG  = op1_q;
    assign ALU_S1REG  = op1_q;
    assign ALU_U2REGX = op2_q;
    assign ALU_S2REGX = op2_q;
    assign RSP_VLD    = rsp_vld_q;
    assign RSP_ID     = rsp_id_q;
    assign RSP_DATA   = rsp_data_q;
    assign BUSY       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arb.sv
// Bench for alu_arb: stand-in ALU, vector table, scoreboard of expected responses, hand-written corner sequences.
module tb_alu_arb;

    logic        CLK = 1'b0;
    logic        RES;
    logic        REQ0_VLD, REQ0_RDY, REQ0_RCC;
    logic [2:0]  REQ0_FCT3;
    logic [6:0]  REQ0_FCT7;
    logic [31:0] REQ0_OP1, REQ0_OP2;
    logic        REQ1_VLD, REQ1_RDY, REQ1_RCC;
    logic [2:0]  REQ1_FCT3;
    logic [6:0]  REQ1_FCT7;
    logic [31:0] REQ1_OP1, REQ1_OP2;
    logic        ALU_RCC;
    logic [2:0]  ALU_FCT3;
    logic [6:0]  ALU_FCT7;
    logic [31:0] ALU_U1REG, ALU_S1REG, ALU_U2REGX, ALU_S2REGX, ALU_RMDATA;
    logic        RSP_VLD, RSP_RDY, RSP_ID, BUSY;
    logic [31:0] RSP_DATA;

    always #5 CLK = ~CLK;

    alu_arb #(.RR_INIT(1'b0)) dut (
        .CLK(CLK), .RES(RES),
        .REQ0_VLD(REQ0_VLD), .REQ0_RDY(REQ0_RDY), .REQ0_RCC(REQ0_RCC),
        .REQ0_FCT3(REQ0_FCT3), .REQ0_FCT7(REQ0_FCT7), .REQ0_OP1(REQ0_OP1), .REQ0_OP2(REQ0_OP2),
        .REQ1_VLD(REQ1_VLD), .REQ1_RDY(REQ1_RDY), .REQ1_RCC(REQ1_RCC),
        .REQ1_FCT3(REQ1_FCT3), .REQ1_FCT7(REQ1_FCT7), .REQ1_OP1(REQ1_OP1), .REQ1_OP2(REQ1_OP2),
        .ALU_RCC(ALU_RCC), .ALU_FCT3(ALU_FCT3), .ALU_FCT7(ALU_FCT7),
        .ALU_U1REG(ALU_U1REG), .ALU_S1REG(ALU_S1REG),
        .ALU_U2REGX(ALU_U2REGX), .ALU_S2REGX(ALU_S2REGX), .ALU_RMDATA(ALU_RMDATA),
        .RSP_VLD(RSP_VLD), .RSP_RDY(RSP_RDY), .RSP_ID(RSP_ID), .RSP_DATA(RSP_DATA), .BUSY(BUSY)
    );

    // Stand-in for the shared RV32 integer ALU the arbiter drives.
    always_comb begin
        case (ALU_FCT3)
            3'd0:    ALU_RMDATA = (ALU_RCC && ALU_FCT7[5]) ? ALU_U1REG - ALU_U2REGX : ALU_U1REG + ALU_U2REGX;
            3'd1:    ALU_RMDATA = ALU_U1REG << ALU_U2REGX[4:0];
            3'd2:    ALU_RMDATA = {31'd0, $signed(ALU_S1REG) < $signed(ALU_S2REGX)};
            3'd3:    ALU_RMDATA = {31'd0, ALU_U1REG < ALU_U2REGX};
            3'd4:    ALU_RMDATA = ALU_U1REG ^ ALU_U2REGX;
            3'd5:    ALU_RMDATA = ALU_FCT7[5] ? 32'($signed(ALU_S1REG) >>> ALU_U2REGX[4:0])
                                              : ALU_U1REG >> ALU_U2REGX[4:0];
            3'd6:    ALU_RMDATA = ALU_U1REG | ALU_U2REGX;
            default: ALU_RMDATA = ALU_U1REG & ALU_U2REGX;
        endcase
    end

    typedef struct {
        logic        id;
        logic        rcc;
        logic [2:0]  fct3;
        logic [6:0]  fct7;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic        id;
        logic [31:0] data;
    } rsp_t;

    rsp_t sb[$];
    vec_t tbl[10];
    int   checks = 0;
    int   fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Score any response transferring at the coming edge, then advance to just after the next falling edge.
    task automatic step();
        rsp_t e;
        if (!RES && RSP_VLD && RSP_RDY) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_rsp: got id %0d data 0x%08h, expected no response", RSP_ID, RSP_DATA);
            end else begin
                e = sb.pop_front();
                $display("rsp id=%0d data=0x%08h (expected id=%0d data=0x%08h)", RSP_ID, RSP_DATA, e.id, e.data);
                chk("rsp_id", {31'd0, RSP_ID}, {31'd0, e.id});
                chk("rsp_data", RSP_DATA, e.data);
            end
        end
        @(negedge CLK);
        #1;
    endtask

    task automatic drive(input vec_t v, input logic vld);
        if (v.id) begin
            REQ1_VLD = vld; REQ1_RCC = v.rcc; REQ1_FCT3 = v.fct3; REQ1_FCT7 = v.fct7;
            REQ1_OP1 = v.op1; REQ1_OP2 = v.op2;
        end else begin
            REQ0_VLD = vld; REQ0_RCC = v.rcc; REQ0_FCT3 = v.fct3; REQ0_FCT7 = v.fct7;
            REQ0_OP1 = v.op1; REQ0_OP2 = v.op2;
        end
    endtask

    // Present one request, wait (bounded) for its grant, record the expected result; returns just after the accepting edge.
    task automatic send(input vec_t v);
        int   n;
        rsp_t e;
        drive(v, 1'b1);
        #1;
        n = 0;
        while (!(v.id ? REQ1_RDY : REQ0_RDY) && n < 20) begin
            step();
            n++;
        end
        if (!(v.id ? REQ1_RDY : REQ0_RDY)) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout: requester %0d got no grant in 20 cycles, expected a grant", v.id);
        end else begin
            e.id = v.id;
            e.data = v.exp;
            sb.push_back(e);
            $display("req id=%0d fct3=%0d op1=0x%08h op2=0x%08h", v.id, v.fct3, v.op1, v.op2);
        end
        step();
        drive(v, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v, w;
        rsp_t e;
        logic exp_g;
        logic saw_vld;
        int   grants;

        tbl[0] = '{1'b1, 1'b1, 3'd0, 7'h20, 32'd3,          32'd5,          32'hFFFF_FFFE};
        tbl[1] = '{1'b0, 1'b0, 3'd0, 7'h20, 32'd7,          32'd2,          32'd9};
        tbl[2] = '{1'b1, 1'b0, 3'd4, 7'h00, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0};
        tbl[3] = '{1'b0, 1'b1, 3'd1, 7'h00, 32'd1,          32'd31,         32'h8000_0000};
        tbl[4] = '{1'b1, 1'b1, 3'd5, 7'h00, 32'h8000_0000,  32'd4,          32'h0800_0000};
        tbl[5] = '{1'b0, 1'b1, 3'd7, 7'h00, 32'h1234_ABCD,  32'h0000_FFFF,  32'h0000_ABCD};
        tbl[6] = '{1'b1, 1'b1, 3'd6, 7'h00, 32'h00F0_0000,  32'h0000_000F,  32'h00F0_000F};
        tbl[7] = '{1'b0, 1'b1, 3'd3, 7'h00, 32'd1,          32'hFFFF_FFFF,  32'd1};
        tbl[8] = '{1'b1, 1'b1, 3'd2, 7'h00, 32'hFFFF_FFFF,  32'd1,          32'd1};
        tbl[9] = '{1'b0, 1'b1, 3'd0, 7'h20, 32'd100,        32'd1,          32'd99};

        RES = 1'b1; RSP_RDY = 1'b1;
        REQ0_VLD = 0; REQ0_RCC = 0; REQ0_FCT3 = 0; REQ0_FCT7 = 0; REQ0_OP1 = 0; REQ0_OP2 = 0;
        REQ1_VLD = 0; REQ1_RCC = 0; REQ1_FCT3 = 0; REQ1_FCT7 = 0; REQ1_OP1 = 0; REQ1_OP2 = 0;
        @(negedge CLK); #1;
        step();
        chk("rst_rsp_vld", {31'd0, RSP_VLD}, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_rsp_data", RSP_DATA, 32'd0);
        chk("rst_alu_op1", ALU_U1REG, 32'd0);
        chk("rst_alu_fct3", {29'd0, ALU_FCT3}, 32'd0);
        RES = 1'b0;

        // ADD from requester 0: one EXEC cycle, then the response.
        v = '{1'b0, 1'b0, 3'd0, 7'h00, 32'd5, 32'd3, 32'd8};
        send(v);
        chk("lat_exec_rsp_vld", {31'd0, RSP_VLD}, 32'd0);
        chk("lat_exec_busy", {31'd0, BUSY}, 32'd1);
        step();
        chk("lat_rsp_vld", {31'd0, RSP_VLD}, 32'd1);
        chk("lat_rsp_id", {31'd0, RSP_ID}, 32'd0);
        chk("lat_rsp_data", RSP_DATA, 32'd8);
        chk("alu_u1", ALU_U1REG, 32'd5);
        chk("alu_s1", ALU_S1REG, 32'd5);
        chk("alu_u2", ALU_U2REGX, 32'd3);
        chk("alu_s2", ALU_S2REGX, 32'd3);
        step();
        step();
        chk("idle_busy", {31'd0, BUSY}, 32'd0);

        for (int i = 0; i < 10; i++) send(tbl[i]);
        repeat (4) step();
        chk("tbl_drained", sb.size(), 32'd0);

        // SRA with the consumer stalled: result, owner and ALU drive must hold; nothing accepted.
        RSP_RDY = 1'b0;
        v = '{1'b0, 1'b1, 3'd5, 7'h20, 32'h8000_0000, 32'd4, 32'hF800_0000};
        send(v);
        step();
        w = '{1'b1, 1'b0, 3'd6, 7'h00, 32'h1111_1111, 32'h2222_2222, 32'd0};
        drive(w, 1'b1);
        v.op1 = 32'h0000_0042;
        drive(v, 1'b1);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("hold_rsp_vld", {31'd0, RSP_VLD}, 32'd1);
            chk("hold_rsp_data", RSP_DATA, 32'hF800_0000);
            chk("hold_rsp_id", {31'd0, RSP_ID}, 32'd0);
            chk("hold_rdy0", {31'd0, REQ0_RDY}, 32'd0);
            chk("hold_rdy1", {31'd0, REQ1_RDY}, 32'd0);
            chk("hold_busy", {31'd0, BUSY}, 32'd1);
            chk("hold_alu_op1", ALU_U1REG, 32'h8000_0000);
            step();
        end
        drive(w, 1'b0);
        drive(v, 1'b0);
        RSP_RDY = 1'b1;
        #1;
        chk("withdrawn_rdy0", {31'd0, REQ0_RDY}, 32'd0);
        chk("withdrawn_rdy1", {31'd0, REQ1_RDY}, 32'd0);
        step();
        step();
        chk("hold_drained", sb.size(), 32'd0);
        chk("hold_idle", {31'd0, BUSY}, 32'd0);

        // Round-robin from a fresh reset with both requesters always valid.
        RES = 1'b1;
        step();
        RES = 1'b0;
        v = '{1'b0, 1'b0, 3'd0, 7'h00, 32'd1,  32'd1,  32'd2};
        w = '{1'b1, 1'b0, 3'd0, 7'h00, 32'd10, 32'd20, 32'd30};
        drive(v, 1'b1);
        drive(w, 1'b1);
        #1;
        exp_g = 1'b0;
        grants = 0;
        for (int i = 0; i < 12; i++) begin
            if (REQ0_RDY || REQ1_RDY) begin
                chk("rr_onehot", {31'd0, REQ0_RDY & REQ1_RDY}, 32'd0);
                chk("rr_grant", {31'd0, REQ1_RDY}, {31'd0, exp_g});
                e.id = exp_g;
                e.data = exp_g ? 32'd30 : 32'd2;
                sb.push_back(e);
                $display("req rr grant expected=%0d", exp_g);
                exp_g = ~exp_g;
                grants++;
            end
            step();
        end
        chk("rr_grant_count", grants, 32'd6);
        drive(v, 1'b0);
        drive(w, 1'b0);
        repeat (4) step();
        chk("rr_drained", sb.size(), 32'd0);

        // Reset pulse during EXEC drops the operation.
        v = '{1'b1, 1'b0, 3'd4, 7'h00, 32'hAAAA_0000, 32'h0000_5555, 32'hAAAA_5555};
        send(v);
        chk("pre_rst_busy", {31'd0, BUSY}, 32'd1);
        RES = 1'b1;
        #1;
        chk("mid_rst_rsp_vld", {31'd0, RSP_VLD}, 32'd0);
        chk("mid_rst_busy", {31'd0, BUSY}, 32'd0);
        chk("mid_rst_rsp_data", RSP_DATA, 32'd0);
        chk("mid_rst_rsp_id", {31'd0, RSP_ID}, 32'd0);
        chk("mid_rst_alu_op1", ALU_U1REG, 32'd0);
        chk("mid_rst_alu_fct7", {25'd0, ALU_FCT7}, 32'd0);
        sb.delete();
        #1;
        RES = 1'b0;
        saw_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (RSP_VLD) saw_vld = 1'b1;
            step();
        end
        chk("dropped_no_rsp", {31'd0, saw_vld}, 32'd0);
        v = '{1'b0, 1'b1, 3'd0, 7'h20, 32'd50, 32'd8, 32'd42};
        send(v);
        repeat (3) step();
        chk("final_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 Parameter: RR_INIT, default 0, requester that wins the first simultaneous-request tie after reset.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RES  in  1  reset, asynchronous, active-high.
REQ-004 REQ0_VLD / REQ1_VLD  in  1  requester n has an operation pending.
REQ-005 REQ0_RDY / REQ1_RDY  out  1  arbiter accepts requester n this cycle; transfer when VLD&RDY.
REQ-006 REQn_RCC  in  1  register-class op; enables SUB select; one per requester.
REQ-007 REQn_FCT3  in  3  ALU function; one per requester.
REQ-008 REQn_FCT7  in  7  ALU modifier; bit 5 selects SUB/SRA; one per requester.
REQ-009 REQn_OP1 / REQn_OP2  in  32  operands; one pair per requester.
REQ-010 ALU_RCC, ALU_FCT3, ALU_FCT7  out  1/3/7  registered controls to the shared ALU.
REQ-011 ALU_U1REG, ALU_S1REG  out  32  both equal the registered OP1.
REQ-012 ALU_U2REGX, ALU_S2REGX  out  32  both equal the registered OP2.
REQ-013 ALU_RMDATA  in  32  combinational ALU result.
REQ-014 RSP_VLD  out  1  response valid.
REQ-015 RSP_RDY  in  1  consumer accepts response; transfer when VLD&RDY.
REQ-016 RSP_ID  out  1  index of the requester owning the response.
REQ-017 RSP_DATA  out  32  registered ALU result.
REQ-018 BUSY  out  1  high whenever state is not IDLE.

Function
REQ-019 States SHALL be IDLE, EXEC, RESP.
REQ-020 REQn_RDY SHALL be high only for the granted requester, and only in IDLE or in RESP with RSP_RDY=1.
REQ-021 Grant SHALL go to the sole valid requester; if both are valid, it goes to the one not granted last (round-robin).
REQ-022 The last-grant pointer SHALL update only on an accepted transfer.
REQ-023 On accept, FCT3/FCT7/RCC/OP1/OP2 SHALL be captured into the ALU-drive registers with the owner ID, and the state goes to EXEC.
REQ-024 In EXEC, RSP_DATA SHALL capture ALU_RMDATA, RSP_VLD goes to 1, and the state goes to RESP.
REQ-025 Latency: accept at edge N, RSP_VLD=1 after edge N+1; one idle-free cycle between accept and response.
REQ-026 In RSP_VLD=1 with RSP_RDY=0, RSP_DATA/RSP_ID SHALL hold stable, no request is accepted, and ALU-drive registers hold.
REQ-027 In RESP with RSP_RDY=1 and a valid request, a new accept SHALL occur in the same cycle and the state goes to EXEC (back-to-back, one op per 2 cycles).
REQ-028 In RESP with RSP_RDY=1 and no request, RSP_VLD SHALL clear and the state goes to IDLE.
REQ-029 The arbiter SHALL NOT modify operands; all width, sign and shift semantics come from the ALU.
REQ-030 A requester deasserting VLD without a transfer SHALL NOT be granted; no queueing is performed.

Reset
REQ-031 While RES=1 (async), state=IDLE, RSP_VLD=0, RSP_DATA=0, RSP_ID=0, BUSY=0, all ALU-drive registers=0, last-grant=~RR_INIT.
REQ-032 Reset mid EXEC/RESP SHALL drop the in-flight operation with no response produced.
REQ-033 After RES falls, REQn_RDY SHALL follow REQ-020/021 from the first edge.

Verification
REQ-034 REQ0 ADD (FCT3=0, RCC=0) OP1=5, OP2=3 accepted at edge N -> RSP_VLD=1, RSP_ID=0, RSP_DATA=8 after edge N+1.
REQ-035 Both VLD high continuously after reset, RR_INIT=0, RSP_RDY=1 -> grants alternate 0,1,0,1; RSP_ID sequence matches.
REQ-036 REQ1 SUB (FCT3=0, RCC=1, FCT7=0x20) 3-5 -> RSP_DATA=0xFFFFFFFE, RSP_ID=1.
REQ-037 REQ0 SRA (FCT3=5, FCT7=0x20) 0x80000000 by 4, RSP_RDY held low 3 cycles -> RSP_DATA=0xF8000000 stable for those cycles, both REQn_RDY=0, BUSY=1.
REQ-038 Pulse RES while in EXEC -> RSP_VLD never asserts for that op; outputs read reset values; next request completes normally.
